// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and operand
// forward-select codes.
package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/exec_alu.sv
// Combinational 32-bit ALU; shifts operate on b by shamt, LUI moves b into
// the upper half.
module exec_alu
    import exec_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  result = b << 16;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/pipeline_exmem.sv
// Execute stage with the EX/MEM pipeline register: operand forwarding, ALU,
// branch/jump resolution with fetch redirect, and taken-branch/jump counters.
module pipeline_exmem
    import exec_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int RA_REG = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      IRin,
    input  logic [31:0]      PCin,
    input  logic [31:0]      r1in,
    input  logic [31:0]      r2in,
    input  logic [1:0]       f1in,
    input  logic [1:0]       f2in,
    input  logic             mtrin,
    input  logic             rdin,
    input  logic             jalin,
    input  logic             sravin,
    input  logic             sbin,
    input  logic             rwin,
    input  logic             mwin,
    input  logic [3:0]       aluopin,
    input  logic             alusrcin,
    input  logic             sextin,
    input  logic             jmpin,
    input  logic             jrin,
    input  logic             beqin,
    input  logic             bnein,
    input  logic             blezin,
    input  logic [31:0]      wb_data,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      IRout,
    output logic [31:0]      PCout,
    output logic [31:0]      resout,
    output logic [31:0]      sdout,
    output logic [4:0]       wregout,
    output logic             mtrout,
    output logic             sbout,
    output logic             rwout,
    output logic             mwout,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] jmp_cnt
);

    logic [31:0] a, bq, b, imm, pc4, alu_res, res_next;
    logic [31:0] br_target, jmp_target;
    logic [4:0]  shamt, wreg_next;
    logic        valid, taken, jump;
    logic        alu_zero_unused;

    always_comb begin
        case (f1in)
            FWD_EXM: a = resout;
            FWD_WB:  a = wb_data;
            default: a = r1in;
        endcase
        case (f2in)
            FWD_EXM: bq = resout;
            FWD_WB:  bq = wb_data;
            default: bq = r2in;
        endcase
    end

    assign imm   = sextin ? {{16{IRin[15]}}, IRin[15:0]} : {16'h0, IRin[15:0]};
    assign b     = alusrcin ? imm : bq;
    assign shamt = sravin ? a[4:0] : IRin[10:6];

    exec_alu u_alu (
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .op     (aluopin),
        .result (alu_res),
        .zero   (alu_zero_unused)
    );

    // An all-zero instruction word is a bubble and must have no side effects.
    assign valid      = (IRin != '0);
    assign pc4        = PCin + 32'd4;
    assign br_target  = pc4 + {{14{IRin[15]}}, IRin[15:0], 2'b00};
    assign jmp_target = {pc4[31:28], IRin[25:0], 2'b00};

    assign taken = valid & ((beqin  & (a == bq)) |
                            (bnein  & (a != bq)) |
                            (blezin & ($signed(a) <= 32'sd0)));
    assign jump  = valid & (jmpin | jrin);

    assign redirect    = ~stall & (jump | taken);
    assign redirect_pc = jrin ? a : (jmpin ? jmp_target : br_target);

    assign wreg_next = jalin ? 5'(RA_REG) : (rdin ? IRin[15:11] : IRin[20:16]);
    assign res_next  = jalin ? pc4 : alu_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            IRout   <= '0;
            PCout   <= '0;
            resout  <= '0;
            sdout   <= '0;
            wregout <= '0;
            mtrout  <= 1'b0;
            sbout   <= 1'b0;
            rwout   <= 1'b0;
            mwout   <= 1'b0;
            br_cnt  <= '0;
            jmp_cnt <= '0;
        end else if (!stall) begin
            if (valid) begin
                IRout   <= IRin;
                PCout   <= PCin;
                resout  <= res_next;
                sdout   <= bq;
                wregout <= wreg_next;
                mtrout  <= mtrin;
                sbout   <= sbin;
                rwout   <= rwin;
                mwout   <= mwin;
            end else begin
                IRout   <= '0;
                PCout   <= '0;
                resout  <= '0;
                sdout   <= '0;
                wregout <= '0;
                mtrout  <= 1'b0;
                sbout   <= 1'b0;
                rwout   <= 1'b0;
                mwout   <= 1'b0;
            end
            if (taken) br_cnt <= br_cnt + CNT_W'(1);
            if (jump)  jmp_cnt <= jmp_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_exmem.sv
// Directed bench for pipeline_exmem: hand-computed results for ALU ops,
// forwarding, branches, jumps, stall hold, counter wrap and reset.
module tb_pipeline_exmem;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [31:0] IRin, PCin, r1in, r2in, wb_data;
    logic [1:0]  f1in, f2in;
    logic        mtrin, rdin, jalin, sravin, sbin, rwin, mwin;
    logic [3:0]  aluopin;
    logic        alusrcin, sextin, jmpin, jrin, beqin, bnein, blezin;
    logic        redirect;
    logic [31:0] redirect_pc, IRout, PCout, resout, sdout;
    logic [4:0]  wregout;
    logic        mtrout, sbout, rwout, mwout;
    logic [15:0] br_cnt, jmp_cnt;

    int checks = 0;
    int failures = 0;
    int exp_br = 0;
    int exp_jmp = 0;

    pipeline_exmem #(.CNT_W(16), .RA_REG(31)) dut (
        .clk(clk), .rst(rst), .stall(stall), .IRin(IRin), .PCin(PCin),
        .r1in(r1in), .r2in(r2in), .f1in(f1in), .f2in(f2in),
        .mtrin(mtrin), .rdin(rdin), .jalin(jalin), .sravin(sravin),
        .sbin(sbin), .rwin(rwin), .mwin(mwin), .aluopin(aluopin),
        .alusrcin(alusrcin), .sextin(sextin), .jmpin(jmpin), .jrin(jrin),
        .beqin(beqin), .bnein(bnein), .blezin(blezin), .wb_data(wb_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .IRout(IRout),
        .PCout(PCout), .resout(resout), .sdout(sdout), .wregout(wregout),
        .mtrout(mtrout), .sbout(sbout), .rwout(rwout), .mwout(mwout),
        .br_cnt(br_cnt), .jmp_cnt(jmp_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Clock in the currently driven inputs, then return at the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearInputs();
        IRin = '0; PCin = '0; r1in = '0; r2in = '0; wb_data = '0;
        f1in = FWD_REG; f2in = FWD_REG;
        mtrin = 0; rdin = 0; jalin = 0; sravin = 0; sbin = 0; rwin = 0; mwin = 0;
        aluopin = ALU_ADD; alusrcin = 0; sextin = 0;
        jmpin = 0; jrin = 0; beqin = 0; bnein = 0; blezin = 0;
    endtask

    task automatic setTakenBeq();
        clearInputs();
        IRin = 32'h10220003; PCin = 32'h100; r1in = 32'd9; r2in = 32'd9;
        aluopin = ALU_SUB; beqin = 1;
    endtask

    initial begin
        clearInputs();
        stall = 0;
        rst = 1;
        r1in = 32'h55;
        applyStimulus();
        checkOutput("rst_irout", IRout, 0);
        checkOutput("rst_resout", resout, 0);
        checkOutput("rst_ctrl", {27'b0, wregout} | {28'b0, mtrout, sbout, rwout, mwout}, 0);
        checkOutput("rst_cnts", {br_cnt, jmp_cnt}, 0);

        rst = 0;
        #1 checkOutput("bubble_redirect", {31'b0, redirect}, 0);
        applyStimulus();
        checkOutput("bubble_resout", resout, 0);
        checkOutput("bubble_rwout", {31'b0, rwout}, 0);

        // addi r2, r1, -1 with r1 = 5
        clearInputs();
        IRin = 32'h2022FFFF; PCin = 32'h40; r1in = 32'd5;
        aluopin = ALU_ADD; alusrcin = 1; sextin = 1; rwin = 1;
        applyStimulus();
        checkOutput("addi_res", resout, 32'd4);
        checkOutput("addi_wreg", {27'b0, wregout}, 32'd2);
        checkOutput("addi_rw", {31'b0, rwout}, 1);
        checkOutput("addi_pc", PCout, 32'h40);

        clearInputs();
        IRin = 32'h00221820; r1in = 32'd10; r2in = 32'd20; rdin = 1; rwin = 1;
        applyStimulus();
        checkOutput("add_res", resout, 32'd30);
        checkOutput("add_wreg", {27'b0, wregout}, 32'd3);

        clearInputs();
        IRin = 32'h00221822; r1in = 32'd999; r2in = 32'd7; f1in = FWD_EXM;
        aluopin = ALU_SUB; rdin = 1; rwin = 1;
        applyStimulus();
        checkOutput("sub_fwd_exm", resout, 32'd23);

        clearInputs();
        IRin = 32'h00221820; r1in = 32'd1; r2in = 32'hDEAD; f2in = FWD_WB;
        wb_data = 32'h1234; rdin = 1; rwin = 1;
        applyStimulus();
        checkOutput("add_fwd_wb", resout, 32'h1235);
        checkOutput("sd_fwd_wb", sdout, 32'h1234);

        clearInputs();
        IRin = 32'h00021903; r2in = 32'h80000000; aluopin = ALU_SRA; rdin = 1;
        applyStimulus();
        checkOutput("sra_res", resout, 32'hF8000000);

        clearInputs();
        IRin = 32'h00221820; r1in = 32'hFFFFFFFF; r2in = 32'd1; aluopin = ALU_SLT;
        applyStimulus();
        checkOutput("slt_res", resout, 32'd1);
        aluopin = ALU_SLTU;
        applyStimulus();
        checkOutput("sltu_res", resout, 32'd0);

        clearInputs();
        IRin = 32'h3C041234; aluopin = ALU_LUI; alusrcin = 1;
        applyStimulus();
        checkOutput("lui_res", resout, 32'h12340000);
        checkOutput("lui_wreg", {27'b0, wregout}, 32'd4);

        clearInputs();
        IRin = 32'hAC220008; r1in = 32'h100; r2in = 32'hCAFEF00D;
        alusrcin = 1; sextin = 1; mwin = 1;
        applyStimulus();
        checkOutput("sw_addr", resout, 32'h108);
        checkOutput("sw_data", sdout, 32'hCAFEF00D);
        checkOutput("sw_ctrl", {30'b0, mwout, rwout}, 32'b10);

        setTakenBeq();
        #1 checkOutput("beq_redirect", {31'b0, redirect}, 1);
        checkOutput("beq_target", redirect_pc, 32'h110);
        applyStimulus();
        exp_br++;
        checkOutput("beq_br_cnt", {16'b0, br_cnt}, exp_br);

        r2in = 32'd8;
        #1 checkOutput("beq_nt_redirect", {31'b0, redirect}, 0);
        applyStimulus();
        checkOutput("beq_nt_br_cnt", {16'b0, br_cnt}, exp_br);

        clearInputs();
        IRin = 32'h0C000040; PCin = 32'h200; jmpin = 1; jalin = 1; rwin = 1;
        #1 checkOutput("jal_redirect", {31'b0, redirect}, 1);
        checkOutput("jal_target", redirect_pc, 32'h100);
        applyStimulus();
        exp_jmp++;
        checkOutput("jal_res", resout, 32'h204);
        checkOutput("jal_wreg", {27'b0, wregout}, 32'd31);
        checkOutput("jal_jmp_cnt", {16'b0, jmp_cnt}, exp_jmp);

        clearInputs();
        IRin = 32'h03E00008; PCin = 32'h210; r1in = 32'h3C; jrin = 1;
        #1 checkOutput("jr_target", redirect_pc, 32'h3C);
        applyStimulus();
        exp_jmp++;
        checkOutput("jr_jmp_cnt", {16'b0, jmp_cnt}, exp_jmp);

        clearInputs();
        IRin = 32'h14220003; PCin = 32'h300; r1in = 32'd1; r2in = 32'd2;
        aluopin = ALU_SUB; bnein = 1; rwin = 1;
        stall = 1;
        #1 checkOutput("stall_redirect", {31'b0, redirect}, 0);
        applyStimulus();
        checkOutput("stall_hold_res", resout, 32'h3C);
        checkOutput("stall_hold_ir", IRout, 32'h03E00008);
        checkOutput("stall_hold_cnts", {br_cnt, jmp_cnt}, {exp_br[15:0], exp_jmp[15:0]});
        stall = 0;
        #1 checkOutput("bne_target", redirect_pc, 32'h310);
        applyStimulus();
        exp_br++;
        checkOutput("bne_br_cnt", {16'b0, br_cnt}, exp_br);

        setTakenBeq();
        while (exp_br < 32'hFFFF) begin
            applyStimulus();
            exp_br++;
        end
        checkOutput("br_cnt_max", {16'b0, br_cnt}, 32'hFFFF);
        applyStimulus();
        checkOutput("br_cnt_wrap", {16'b0, br_cnt}, 0);
        checkOutput("wrap_jmp_cnt", {16'b0, jmp_cnt}, exp_jmp);

        clearInputs();
        IRin = 32'h0C000040; PCin = 32'h200; jmpin = 1; jalin = 1; rwin = 1;
        rst = 1; stall = 1;
        applyStimulus();
        checkOutput("midrst_res", resout, 0);
        checkOutput("midrst_ctrl", {27'b0, wregout} | {31'b0, rwout}, 0);
        checkOutput("midrst_cnts", {br_cnt, jmp_cnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
